// File: rtl/tag_issue_ctrl.sv
// tag_issue_ctrl: issues a job's nonzero row tags to the column allocator with busy-retry and NUM_COL credit limiting.
module tag_issue_ctrl #(
  parameter int NUM_COL = 8,
  parameter int TAG_W   = $clog2(NUM_COL) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       cfg_kernel_size,
  input  logic [15:0]      cfg_num_tags,
  input  logic             flush_busy,
  input  logic             tag_retire,
  output logic             flush,
  output logic [TAG_W-1:0] tag_in,
  output logic [7:0]       kernel_size,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [TAG_W-1:0] outstanding,
  output logic [15:0]      retry_cnt
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;
  localparam logic [TAG_W-1:0] MAX_OUT = TAG_W'(NUM_COL);
  localparam logic [7:0]       MAX_KS  = 8'(NUM_COL);
  state_t           state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d, out_q, out_d;
  logic [15:0]      rem_q, rem_d, retry_q, retry_d;
  logic [7:0]       ks_q, ks_d;
  logic             err_q, err_d;
  logic             cfg_ok, accept;
  assign flush       = state_q == ISSUE && out_q < MAX_OUT;
  assign tag_in      = flush ? tag_q : '0;
  assign kernel_size = ks_q;
  assign busy        = state_q != IDLE;
  assign done        = state_q == DRAIN && out_q == '0;
  assign cfg_err     = err_q;
  assign outstanding = out_q;
  assign retry_cnt   = retry_q;
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    rem_d   = rem_q;
    retry_d = retry_q;
    ks_d    = ks_q;
    err_d   = 1'b0;
    cfg_ok  = cfg_kernel_size != 8'd0 && cfg_kernel_size <= MAX_KS && cfg_num_tags != 16'd0;
    accept  = state_q == WAIT && !flush_busy;
    // an accept absorbs a same-cycle retire; a lone retire never underflows
    out_d   = accept ? (tag_retire ? out_q : out_q + 1'b1)
                     : (tag_retire && out_q != '0) ? out_q - 1'b1 : out_q;
    case (state_q)
      IDLE: if (start) begin
        if (cfg_ok) begin
          ks_d    = cfg_kernel_size;
          rem_d   = cfg_num_tags;
          retry_d = '0;
          tag_d   = TAG_W'(1);
          state_d = ISSUE;
        end else err_d = 1'b1;
      end
      ISSUE: if (flush) state_d = WAIT;
      WAIT: if (flush_busy) begin
        retry_d = retry_q + {15'd0, ~&retry_q};
        state_d = ISSUE;
      end else begin
        tag_d   = &tag_q ? TAG_W'(1) : tag_q + 1'b1;
        rem_d   = rem_q - 16'd1;
        state_d = rem_q == 16'd1 ? DRAIN : ISSUE;
      end
      DRAIN: if (out_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      out_d   = '0;
      rem_d   = '0;
      tag_d   = tag_q;
      retry_d = retry_q;
      ks_d    = ks_q;
      err_d   = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      tag_q   <= TAG_W'(1);
      out_q   <= '0;
      rem_q   <= '0;
      retry_q <= '0;
      ks_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      retry_q <= retry_d;
      ks_q    <= ks_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_tag_issue_ctrl.sv
// tb_tag_issue_ctrl: directed vector table plus hand-written sequences for tag_issue_ctrl (NUM_COL=8, TAG_W=4).
module tb_tag_issue_ctrl;
  logic        clk = 1'b0, rstn = 1'b0;
  logic        start = 1'b0, abort = 1'b0, flush_busy = 1'b0, tag_retire = 1'b0;
  logic [7:0]  cfg_kernel_size = 8'd0;
  logic [15:0] cfg_num_tags = 16'd0;
  logic        flush, busy, done, cfg_err;
  logic [3:0]  tag_in, outstanding;
  logic [7:0]  kernel_size;
  logic [15:0] retry_cnt;
  int n_pass = 0, n_tot = 0;

  tag_issue_ctrl #(.NUM_COL(8)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .cfg_kernel_size(cfg_kernel_size), .cfg_num_tags(cfg_num_tags),
    .flush_busy(flush_busy), .tag_retire(tag_retire),
    .flush(flush), .tag_in(tag_in), .kernel_size(kernel_size), .busy(busy),
    .done(done), .cfg_err(cfg_err), .outstanding(outstanding), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic st, ab, fb, rt;
    logic [7:0] ks;
    logic [15:0] nt;
    logic e_flush;
    logic [3:0] e_tag, e_out;
    logic e_busy, e_done, e_err;
    logic [7:0] e_ks;
  } vec_t;

  function automatic vec_t v(logic st, logic rt, logic [7:0] ks, logic [15:0] nt, logic ef,
                             logic [3:0] et, logic [3:0] eo, logic eb, logic ed, logic ee, logic [7:0] eks);
    vec_t r;
    r = '{st: st, ab: 1'b0, fb: 1'b0, rt: rt, ks: ks, nt: nt, e_flush: ef, e_tag: et, e_out: eo,
          e_busy: eb, e_done: ed, e_err: ee, e_ks: eks};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] ks, input logic [15:0] nt);
    cfg_kernel_size = ks;
    cfg_num_tags = nt;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  vec_t vecs[18];
  int exp_o;

  initial begin
    // job 1 (ks=3, 3 tags, no busy) then retires, then rejected starts
    vecs[0]  = v(1, 0, 3, 3, 1, 1, 0, 1, 0, 0, 3);
    vecs[1]  = v(0, 0, 3, 3, 0, 0, 0, 1, 0, 0, 3);
    vecs[2]  = v(0, 0, 3, 3, 1, 2, 1, 1, 0, 0, 3);
    vecs[3]  = v(0, 0, 3, 3, 0, 0, 1, 1, 0, 0, 3);
    vecs[4]  = v(0, 0, 3, 3, 1, 3, 2, 1, 0, 0, 3);
    vecs[5]  = v(0, 0, 3, 3, 0, 0, 2, 1, 0, 0, 3);
    vecs[6]  = v(0, 0, 3, 3, 0, 0, 3, 1, 0, 0, 3);
    vecs[7]  = v(0, 1, 3, 3, 0, 0, 2, 1, 0, 0, 3);
    vecs[8]  = v(0, 1, 3, 3, 0, 0, 1, 1, 0, 0, 3);
    vecs[9]  = v(0, 1, 3, 3, 0, 0, 0, 1, 1, 0, 3);
    vecs[10] = v(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 3);
    vecs[11] = v(0, 1, 3, 3, 0, 0, 0, 0, 0, 0, 3);
    vecs[12] = v(1, 0, 0, 5, 0, 0, 0, 0, 0, 1, 3);
    vecs[13] = v(0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 3);
    vecs[14] = v(1, 0, 9, 5, 0, 0, 0, 0, 0, 1, 3);
    vecs[15] = v(0, 0, 9, 5, 0, 0, 0, 0, 0, 0, 3);
    vecs[16] = v(1, 0, 3, 0, 0, 0, 0, 0, 0, 1, 3);
    vecs[17] = v(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 3);

    #12;
    check("reset_outputs", {flush, tag_in, kernel_size, busy, done, cfg_err, outstanding, retry_cnt}, 32'd0);
    rstn = 1'b1;
    tick();

    foreach (vecs[i]) begin
      start = vecs[i].st; abort = vecs[i].ab; flush_busy = vecs[i].fb; tag_retire = vecs[i].rt;
      cfg_kernel_size = vecs[i].ks; cfg_num_tags = vecs[i].nt;
      tick();
      check($sformatf("vec%0d", i), {flush, tag_in, outstanding, busy, done, cfg_err, kernel_size},
            {vecs[i].e_flush, vecs[i].e_tag, vecs[i].e_out, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_err, vecs[i].e_ks});
    end
    start = 1'b0; tag_retire = 1'b0;
    check("retry_after_job1", retry_cnt, 0);

    // busy retry: tag 1 offered three times
    start_job(8'd2, 16'd2);
    check("retry_offer1", {flush, tag_in}, {1'b1, 4'd1});
    flush_busy = 1'b1;
    tick(); tick();
    check("retry_offer2", {flush, tag_in, retry_cnt}, {1'b1, 4'd1, 16'd1});
    tick(); tick();
    check("retry_offer3", {flush, tag_in, retry_cnt}, {1'b1, 4'd1, 16'd2});
    flush_busy = 1'b0;
    tick(); tick();
    check("retry_next_tag2", {flush, tag_in, retry_cnt, outstanding}, {1'b1, 4'd2, 16'd2, 4'd1});
    tick(); tick();
    check("retry_drain", {busy, outstanding}, {1'b1, 4'd2});
    tag_retire = 1'b1;
    tick(); tick();
    check("retry_done", {done, busy}, {1'b1, 1'b1});
    tag_retire = 1'b0;
    tick();
    check("retry_idle", {done, busy}, {1'b0, 1'b0});

    // credit stall at NUM_COL outstanding
    start_job(8'd8, 16'd10);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("credit_offer%0d", k), {flush, tag_in}, {1'b1, 4'(k)});
      tick(); tick();
    end
    check("credit_stall", {flush, tag_in, outstanding, busy}, {1'b0, 4'd0, 4'd8, 1'b1});
    tick();
    check("credit_stall2", {flush, outstanding}, {1'b0, 4'd8});
    tag_retire = 1'b1;
    tick();
    tag_retire = 1'b0;
    check("credit_tag9", {flush, tag_in, outstanding}, {1'b1, 4'd9, 4'd7});
    tick(); tick();
    check("credit_stall3", {flush, outstanding}, {1'b0, 4'd8});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("credit_abort", {busy, outstanding, done, kernel_size}, {1'b0, 4'd0, 1'b0, 8'd8});

    // tag wrap across 15 with same-cycle accept/retire at tag 6
    start_job(8'd1, 16'd17);
    exp_o = 0;
    for (int k = 1; k <= 17; k++) begin
      check($sformatf("wrap_tag%0d", k), {flush, tag_in, outstanding}, {1'b1, 4'(((k - 1) % 15) + 1), 4'(exp_o)});
      tag_retire = exp_o > 1;
      tick();
      if (exp_o > 1) exp_o--;
      tag_retire = (k == 6);
      tick();
      if (k != 6) exp_o++;
      tag_retire = 1'b0;
      if (k == 6) check("accept_retire_net0", outstanding, 4'(exp_o));
    end
    check("wrap_drain", {busy, done, outstanding}, {1'b1, 1'b0, 4'(exp_o)});
    tag_retire = 1'b1;
    while (exp_o > 0) begin tick(); exp_o--; end
    tag_retire = 1'b0;
    check("wrap_done", {done, outstanding, kernel_size}, {1'b1, 4'd0, 8'd1});
    tick();

    // abort in WAIT after two accepts
    start_job(8'd4, 16'd5);
    tick(); tick(); tick(); tick(); tick();
    check("abort_pre", {busy, flush, outstanding}, {1'b1, 1'b0, 4'd2});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_now", {busy, flush, tag_in, outstanding, done, kernel_size}, {1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 8'd4});
    tick();
    check("abort_after", {busy, done}, {1'b0, 1'b0});

    // async reset mid-DRAIN
    start_job(8'd5, 16'd1);
    flush_busy = 1'b1;
    tick(); tick();
    flush_busy = 1'b0;
    tick(); tick();
    check("rst_pre_drain", {busy, outstanding, retry_cnt, kernel_size}, {1'b1, 4'd1, 16'd1, 8'd5});
    rstn = 1'b0;
    #1;
    check("rst_async", {flush, tag_in, kernel_size, busy, done, cfg_err, outstanding, retry_cnt}, 32'd0);
    tick();
    check("rst_held_no_done", {busy, done}, {1'b0, 1'b0});
    rstn = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
